// File: rtl/vendas_pkg.sv
// Shared types and constants for the vending sale controller:
// state encoding, coin codes, default prices and the credit width.
package vendas_pkg;

   localparam int CREDITO_W = 8;
   typedef logic [CREDITO_W-1:0] credito_t;

   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      ACUMULANDO = 2'd1,
      LIBERANDO  = 2'd2,
      DEVOLVENDO = 2'd3
   } estado_e;

   typedef enum logic [1:0] {
      MOEDA_NENHUMA = 2'd0,
      MOEDA_25      = 2'd1,
      MOEDA_50      = 2'd2,
      MOEDA_100     = 2'd3
   } moeda_e;

   localparam int PRECO0_PADRAO      = 100;
   localparam int PRECO1_PADRAO      = 150;
   localparam int PRECO2_PADRAO      = 175;
   localparam int PRECO3_PADRAO      = 200;
   localparam int CREDITO_MAX_PADRAO = 250;

   function automatic credito_t valor_moeda(input logic [1:0] codigo);
      case (moeda_e'(codigo))
         MOEDA_25:  valor_moeda = credito_t'(25);
         MOEDA_50:  valor_moeda = credito_t'(50);
         MOEDA_100: valor_moeda = credito_t'(100);
         default:   valor_moeda = '0;
      endcase
   endfunction

endpackage

// File: rtl/detector_borda.sv
// Falling-edge detector for an active-low timer strobe: the input is registered
// once, then compared with its own history so each low phase fires exactly once.
module detector_borda (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe,
   output logic disparo
);

   logic atual;
   logic anterior;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         atual    <= 1'b0;
         anterior <= 1'b0;
      end else begin
         atual    <= strobe;
         anterior <= atual;
      end
   end

   assign disparo = anterior & ~atual;

endmodule

// File: rtl/controle_venda.sv
// Sale controller: accumulates coin credit, resolves selections against prices,
// and issues dispense/change pulses; estado feeds back to the phase timer.
module controle_venda
   import vendas_pkg::*;
#(
   parameter int PRECO0        = PRECO0_PADRAO,
   parameter int PRECO1        = PRECO1_PADRAO,
   parameter int PRECO2        = PRECO2_PADRAO,
   parameter int PRECO3        = PRECO3_PADRAO,
   parameter int CREDITO_MAX   = CREDITO_MAX_PADRAO,
   parameter int TIMEOUT_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tempoTeclado,
   input  logic       tempoAcumulador,
   input  logic       tempo,
   input  logic [1:0] moeda,
   input  logic [1:0] tecla,
   input  logic       tecla_valida,
   input  logic       cancela,
   output logic [1:0] estado,
   output credito_t   credito,
   output logic [1:0] produto,
   output credito_t   troco,
   output logic       libera,
   output logic       troco_valido,
   output logic       erro,
   output logic       moeda_rejeitada
);

   logic disparo_teclado;
   logic disparo_acumulador;
   logic disparo_tick;

   detector_borda u_borda_teclado (
      .clk(clk), .rst_n(rst_n), .strobe(tempoTeclado), .disparo(disparo_teclado)
   );
   detector_borda u_borda_acumulador (
      .clk(clk), .rst_n(rst_n), .strobe(tempoAcumulador), .disparo(disparo_acumulador)
   );
   detector_borda u_borda_tick (
      .clk(clk), .rst_n(rst_n), .strobe(tempo), .disparo(disparo_tick)
   );

   function automatic credito_t preco(input logic [1:0] idx);
      case (idx)
         2'd0:    preco = credito_t'(PRECO0);
         2'd1:    preco = credito_t'(PRECO1);
         2'd2:    preco = credito_t'(PRECO2);
         default: preco = credito_t'(PRECO3);
      endcase
   endfunction

   estado_e     estado_q, estado_n;
   credito_t    credito_n, troco_n, valor;
   logic [1:0]  produto_n;
   logic        libera_n, troco_valido_n, erro_n, rejeitada_n;
   logic [15:0] ocio_q, ocio_n;
   logic [8:0]  soma;
   logic        aceita;

   assign valor  = valor_moeda(moeda);
   assign soma   = {1'b0, credito} + {1'b0, valor};
   assign aceita = (soma <= 9'(CREDITO_MAX));
   assign estado = estado_q;

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      estado_n       = estado_q;
      credito_n      = credito;
      produto_n      = produto;
      troco_n        = troco;
      ocio_n         = ocio_q;
      libera_n       = 1'b0;
      troco_valido_n = 1'b0;
      erro_n         = 1'b0;
      rejeitada_n    = 1'b0;

      case (estado_q)
         OCIOSO: begin
            credito_n = '0;
            ocio_n    = '0;
            if (disparo_acumulador && moeda != 2'd0) begin
               credito_n = valor;
               estado_n  = ACUMULANDO;
            end
         end

         ACUMULANDO: begin
            if (disparo_acumulador) begin
               if (aceita) begin
                  credito_n = soma[7:0];
                  ocio_n    = '0;
               end else begin
                  rejeitada_n = 1'b1;
               end
            end
            // Selection is judged on the pre-coin credit; an accepted coin rides into the change.
            if (disparo_teclado && cancela) begin
               estado_n       = DEVOLVENDO;
               troco_valido_n = 1'b1;
               troco_n        = credito_n;
               ocio_n         = '0;
            end else if (disparo_teclado && tecla_valida && credito >= preco(tecla)) begin
               estado_n  = LIBERANDO;
               produto_n = tecla;
               libera_n  = 1'b1;
               ocio_n    = '0;
            end else if (disparo_teclado && tecla_valida) begin
               erro_n = 1'b1;
               ocio_n = '0;
            end else if (disparo_tick && !(disparo_acumulador && aceita)) begin
               if (ocio_q + 16'd1 >= 16'(TIMEOUT_TICKS)) begin
                  estado_n       = DEVOLVENDO;
                  troco_valido_n = 1'b1;
                  troco_n        = credito_n;
                  ocio_n         = '0;
               end else begin
                  ocio_n = ocio_q + 16'd1;
               end
            end
         end

         LIBERANDO: begin
            credito_n = credito - preco(produto);
            ocio_n    = '0;
            if (credito_n != '0) begin
               estado_n       = DEVOLVENDO;
               troco_valido_n = 1'b1;
               troco_n        = credito_n;
            end else begin
               estado_n = OCIOSO;
            end
         end

         DEVOLVENDO: begin
            credito_n = '0;
            ocio_n    = '0;
            estado_n  = OCIOSO;
         end

         default: estado_n = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q        <= OCIOSO;
         credito         <= '0;
         produto         <= '0;
         troco           <= '0;
         ocio_q          <= '0;
         libera          <= 1'b0;
         troco_valido    <= 1'b0;
         erro            <= 1'b0;
         moeda_rejeitada <= 1'b0;
      end else begin
         estado_q        <= estado_n;
         credito         <= credito_n;
         produto         <= produto_n;
         troco           <= troco_n;
         ocio_q          <= ocio_n;
         libera          <= libera_n;
         troco_valido    <= troco_valido_n;
         erro            <= erro_n;
         moeda_rejeitada <= rejeitada_n;
      end
   end

endmodule

// File: tb/tb_controle_venda.sv
// Scoreboard bench for controle_venda: a transaction-level sale model queues the
// expected pulses, and a monitor pops and compares whenever the DUT pulses.
module tb_controle_venda;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tempoTeclado, tempoAcumulador, tempo;
   logic [1:0] moeda, tecla;
   logic       tecla_valida, cancela;
   logic [1:0] estado;
   logic [7:0] credito, troco;
   logic [1:0] produto;
   logic       libera, troco_valido, erro, moeda_rejeitada;

   always #5 clk = ~clk;

   controle_venda dut (
      .clk(clk), .rst_n(rst_n),
      .tempoTeclado(tempoTeclado), .tempoAcumulador(tempoAcumulador), .tempo(tempo),
      .moeda(moeda), .tecla(tecla), .tecla_valida(tecla_valida), .cancela(cancela),
      .estado(estado), .credito(credito), .produto(produto), .libera(libera),
      .troco(troco), .troco_valido(troco_valido), .erro(erro),
      .moeda_rejeitada(moeda_rejeitada)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef enum int {EV_REJ, EV_ERR, EV_LIB, EV_TROCO} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       data;
      int       at;
   } ev_t;

   ev_t sb[$];

   int coin_cents[4] = '{0, 25, 50, 100};
   int price[4]      = '{100, 150, 175, 200};
   localparam int MAX_CREDIT = 250;
   localparam int TIMEOUT    = 8;

   int m_credit = 0;
   bit m_active = 0;
   int m_idle   = 0;

   function automatic void push(input ev_kind_e k, input int d, input int at);
      ev_t e;
      e.kind = k; e.data = d; e.at = at;
      sb.push_back(e);
   endfunction

   function automatic void refund(input int base);
      push(EV_TROCO, m_credit, base + 2);
      m_credit = 0; m_active = 0; m_idle = 0;
   endfunction

   function automatic void model_op(input bit c_en, input int c, input bit k_en, input int t,
                                    input bit tv, input bit can, input bit tk, input int base);
      int pre;
      bit clear;
      if (!m_active) begin
         if (c_en && c != 0) begin
            m_credit = coin_cents[c]; m_active = 1; m_idle = 0;
         end
         return;
      end
      pre = m_credit;
      clear = 0;
      if (c_en) begin
         if (pre + coin_cents[c] <= MAX_CREDIT) begin
            m_credit = pre + coin_cents[c]; clear = 1;
         end else begin
            push(EV_REJ, m_credit, base + 2);
         end
      end
      if (k_en && can) begin
         refund(base);
         return;
      end
      if (k_en && tv) begin
         if (pre >= price[t]) begin
            push(EV_LIB, t, base + 2);
            if (m_credit - price[t] > 0) push(EV_TROCO, m_credit - price[t], base + 3);
            m_credit = 0; m_active = 0; m_idle = 0;
            return;
         end
         push(EV_ERR, m_credit, base + 2);
         clear = 1;
      end
      if (clear) m_idle = 0;
      else if (tk) begin
         m_idle++;
         if (m_idle >= TIMEOUT) refund(base);
      end
   endfunction

   // ---------------- monitor ----------------
   task automatic expect_ev(input ev_kind_e k, input int d);
      ev_t e;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected_pulse: kind %0d data %0d at cycle %0d, expected none", k, d, cyc);
      end else begin
         e = sb.pop_front();
         check("pulse_kind", int'(k), int'(e.kind));
         check("pulse_data", d, e.data);
         check("pulse_cycle", cyc, e.at);
      end
   endtask

   always @(negedge clk) begin
      if (moeda_rejeitada) expect_ev(EV_REJ, credito);
      if (erro)            expect_ev(EV_ERR, credito);
      if (libera) begin
         check("estado_in_liberando", estado, 2);
         expect_ev(EV_LIB, produto);
      end
      if (troco_valido) begin
         check("estado_in_devolvendo", estado, 3);
         expect_ev(EV_TROCO, troco);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_op(input bit c_en, input int c, input bit k_en, input int t,
                        input bit tv, input bit can, input bit tk, input int low_len);
      @(negedge clk);
      moeda        = 2'(c);
      tecla        = 2'(t);
      tecla_valida = tv;
      cancela      = can;
      tempoAcumulador = !c_en;
      tempoTeclado    = !k_en;
      tempo           = !tk;
      model_op(c_en, c, k_en, t, tv, can, tk, cyc);
      repeat (low_len) @(negedge clk);
      tempoAcumulador = 1'b1;
      tempoTeclado    = 1'b1;
      tempo           = 1'b1;
      repeat (6) @(negedge clk);
      check("estado_settled", estado, m_active ? 1 : 0);
      check("credito_settled", credito, m_credit);
   endtask

   task automatic coin(input int c);
      do_op(1, c, 0, 0, 0, 0, 0, 1);
   endtask
   task automatic key(input int t, input bit can);
      do_op(0, 0, 1, t, 1, can, 0, 1);
   endtask
   task automatic tick();
      do_op(0, 0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_estado"}, estado, 0);
      check({tag, "_credito"}, credito, 0);
      check({tag, "_troco"}, troco, 0);
      check({tag, "_produto"}, produto, 0);
      check({tag, "_pulses"}, {libera, troco_valido, erro, moeda_rejeitada}, 0);
   endtask

   task automatic apply_reset(input bit hold_acum_low);
      @(negedge clk);
      rst_n = 1'b0;
      if (hold_acum_low) begin
         tempoAcumulador = 1'b0;
         moeda = 2'd3;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_credit = 0; m_active = 0; m_idle = 0;
      repeat (4) @(negedge clk);
      check_reset_outputs("after_reset");
      tempoAcumulador = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      tempoTeclado = 1'b1; tempoAcumulador = 1'b1; tempo = 1'b1;
      moeda = '0; tecla = '0; tecla_valida = 1'b0; cancela = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_outputs("post_release");

      // normal sale with change: 200 credit, product 1 (150)
      coin(3); coin(3); key(1, 0);
      // insufficient credit, then top-up
      coin(2); key(0, 0); coin(3); key(0, 0);
      // saturation: third 100 rejected, 50 accepted to reach 250, then cancel
      coin(3); coin(3); coin(3); coin(2); key(0, 1);
      // timeout after 8 ticks
      coin(1);
      for (int i = 0; i < 8; i++) tick();
      // 7 ticks then a coin: count restarts, no refund
      coin(1);
      for (int i = 0; i < 7; i++) tick();
      coin(1);
      for (int i = 0; i < 7; i++) tick();
      key(0, 1);
      // cancel has priority over a valid selection
      coin(3); coin(3); do_op(0, 0, 1, 0, 1, 1, 0, 1);
      // mid-sale reset with accumulator strobe low through release
      coin(3);
      apply_reset(1);
      // strobe held low for 5 cycles gives one coin
      coin(3); do_op(1, 2, 0, 0, 0, 0, 0, 5);
      key(0, 1);
      // simultaneous coin and key: decision on pre-coin credit
      coin(3); do_op(1, 3, 1, 0, 1, 0, 0, 2);
      coin(3); do_op(1, 2, 1, 1, 1, 0, 0, 2);
      key(0, 1);

      // randomized operations
      for (int i = 0; i < 200; i++) begin
         bit c_en, k_en, tk, tv, can;
         c_en = ($urandom_range(0, 99) < 35);
         k_en = ($urandom_range(0, 99) < 25);
         tk   = ($urandom_range(0, 99) < 50);
         tv   = ($urandom_range(0, 1) == 1);
         can  = ($urandom_range(0, 99) < 15);
         do_op(c_en, int'($urandom_range(0, 3)), k_en, int'($urandom_range(0, 3)),
               tv, can, tk, int'($urandom_range(1, 5)));
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
